// File: rtl/led_sched_pkg.sv
// Shared types, defaults and helpers for the LED blink scheduler.
package led_sched_pkg;

    localparam int unsigned DUR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_DIS = 2'd0,
        ST_ON  = 2'd1,
        ST_OFF = 2'd2
    } ch_state_e;

    // Clock cycles per timebase tick.
    function automatic int unsigned tick_div(input int unsigned clk_freq,
                                             input int unsigned tick_hz);
        return clk_freq / tick_hz;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Shared timebase: free-running prescaler with a registered one-cycle tick.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;

    // Prescaler wraps at TICK_DIV-1; tick fires the cycle after the wrap point.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (presc_q == LAST);
            presc_q <= (presc_q == LAST) ? '0 : presc_q + PW'(1);
        end
    end

endmodule

// File: rtl/led_blink_sched.sv
// Multi-channel LED blink scheduler sharing one tick timebase.
module led_blink_sched
    import led_sched_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned N_LED    = 4,
    parameter int unsigned DUR_W    = DUR_W_DEF,
    localparam int unsigned CH_W    = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic             Clk50M,
    input  logic             Rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_en,
    input  logic [DUR_W-1:0] cfg_on,
    input  logic [DUR_W-1:0] cfg_off,
    output logic             tick,
    output logic [N_LED-1:0] led
);

    localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, TICK_HZ);

    logic ready_q;
    logic tick_q;
    logic accept;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (Clk50M),
        .rst  (Rst),
        .tick (tick_q)
    );

    // Config port becomes ready one cycle after reset release.
    always_ff @(posedge Clk50M) begin
        if (Rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Blocking accepts during tick keeps config writes and tick updates disjoint.
    assign cfg_ready = ready_q & ~tick_q;
    assign accept    = cfg_valid & cfg_ready;
    assign tick      = tick_q;

    for (genvar i = 0; i < int'(N_LED); i++) begin : g_ch
        ch_state_e        state_q;
        logic [DUR_W-1:0] rem_q;
        logic [DUR_W-1:0] on_q;
        logic [DUR_W-1:0] off_q;
        logic             led_q;
        logic             sel;

        assign sel = accept && (32'(cfg_ch) == 32'(i));

        // Channel sequencer: accept restarts the channel, ticks count down phases.
        always_ff @(posedge Clk50M) begin
            if (Rst) begin
                state_q <= ST_DIS;
                rem_q   <= '0;
                on_q    <= '0;
                off_q   <= '0;
                led_q   <= 1'b0;
            end else if (sel) begin
                on_q  <= cfg_on;
                off_q <= cfg_off;
                if (!cfg_en || (cfg_on == '0 && cfg_off == '0)) begin
                    state_q <= ST_DIS;
                    rem_q   <= '0;
                    led_q   <= 1'b0;
                end else if (cfg_on != '0) begin
                    state_q <= ST_ON;
                    rem_q   <= cfg_on;
                    led_q   <= 1'b1;
                end else begin
                    state_q <= ST_OFF;
                    rem_q   <= cfg_off;
                    led_q   <= 1'b0;
                end
            end else if (tick_q && state_q != ST_DIS) begin
                if (rem_q > DUR_W'(1)) begin
                    rem_q <= rem_q - DUR_W'(1);
                end else if (state_q == ST_ON) begin
                    if (off_q != '0) begin
                        state_q <= ST_OFF;
                        rem_q   <= off_q;
                        led_q   <= 1'b0;
                    end else begin
                        rem_q   <= on_q;
                    end
                end else begin
                    if (on_q != '0) begin
                        state_q <= ST_ON;
                        rem_q   <= on_q;
                        led_q   <= 1'b1;
                    end else begin
                        rem_q   <= off_q;
                    end
                end
            end
        end

        assign led[i] = led_q;
    end

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: tick-count reference model plus literal pins.
module tb_led_blink_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned TD = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic          cfg_en = 1'b0;
    logic [DW-1:0] cfg_on = '0;
    logic [DW-1:0] cfg_off = '0;
    logic          cfg_ready;
    logic          tick;
    logic [N-1:0]  led;

    int n_chk  = 0;
    int n_fail = 0;

    led_blink_sched #(
        .CLK_FREQ (1000),
        .TICK_HZ  (100),
        .N_LED    (N),
        .DUR_W    (DW)
    ) dut (
        .Clk50M    (clk),
        .Rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_en    (cfg_en),
        .cfg_on    (cfg_on),
        .cfg_off   (cfg_off),
        .tick      (tick),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a channel's LED is a function of its config and the ticks seen since accept.
    function automatic bit lit(input int en, input int on, input int off, input int k);
        if (en == 0 || on == 0) return 1'b0;
        if (off == 0 || k < on) return 1'b1;
        return ((k - on) % (on + off)) >= off;
    endfunction

    int           n_edge = 0;
    bit           tick_e = 1'b0;
    bit           cr_e   = 1'b0;
    int           m_en[N];
    int           m_on[N];
    int           m_off[N];
    int           m_k[N];
    logic [N-1:0] led_e;

    // Model update at each edge, then compare every output just after it.
    always @(posedge clk) begin : model
        bit tick_prev;
        bit cr_prev;
        tick_prev = tick_e;
        cr_prev   = cr_e;
        if (rst) begin
            n_edge = 0;
            tick_e = 1'b0;
            cr_e   = 1'b0;
            for (int c = 0; c < int'(N); c++) begin
                m_en[c] = 0; m_on[c] = 0; m_off[c] = 0; m_k[c] = 0;
            end
        end else begin
            for (int c = 0; c < int'(N); c++)
                if (m_en[c] != 0 && tick_prev) m_k[c]++;
            if (cfg_valid && cr_prev && int'(cfg_ch) < int'(N)) begin
                m_en[int'(cfg_ch)]  = int'(cfg_en);
                m_on[int'(cfg_ch)]  = int'(cfg_on);
                m_off[int'(cfg_ch)] = int'(cfg_off);
                m_k[int'(cfg_ch)]   = 0;
            end
            n_edge++;
            tick_e = (n_edge % int'(TD)) == 0;
            cr_e   = !tick_e;
        end
        for (int c = 0; c < int'(N); c++)
            led_e[c] = lit(m_en[c], m_on[c], m_off[c], m_k[c]);
        #1;
        chk("model_tick", 32'(tick), 32'(tick_e));
        chk("model_cfg_ready", 32'(cfg_ready), 32'(cr_e));
        chk("model_led", 32'(led), 32'(led_e));
    end

    task automatic send(input int ch, input int en, input int on, input int off);
        int w;
        @(negedge clk);
        cfg_ch    = 2'(ch);
        cfg_en    = 1'(en);
        cfg_on    = DW'(on);
        cfg_off   = DW'(off);
        cfg_valid = 1'b1;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("send_timeout", 32'(w), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin : main
        int tcnt;
        int w;
        int bad1;
        int bad2;

        // Reset hold
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_outputs", {tick, cfg_ready, 2'b00, led}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(cfg_ready), 32'd1);

        // Free run: ticks at edges 10,20,30,40,50 after release
        tcnt = 0;
        for (int c = 2; c <= 50; c++) begin
            @(negedge clk);
            if (tick) tcnt++;
            if (c == 9)  chk("tick_edge9", 32'(tick), 32'd0);
            if (c == 10) chk("tick_edge10", 32'(tick), 32'd1);
            if (c == 11) chk("tick_edge11", 32'(tick), 32'd0);
        end
        chk("tick_count_50", 32'(tcnt), 32'd5);

        // ch0 blink 2 on / 3 off
        send(0, 1, 2, 3);
        chk("ch0_lit_after_accept", 32'(led[0]), 32'd1);
        w = 0;
        while (led[0] === 1'b1 && w < 200) begin @(negedge clk); w++; end
        w = 0;
        while (led[0] === 1'b0 && w < 200) begin @(negedge clk); w++; end
        chk("ch0_off_cycles", 32'(w), 32'd30);
        w = 0;
        while (led[0] === 1'b1 && w < 200) begin @(negedge clk); w++; end
        chk("ch0_on_cycles", 32'(w), 32'd20);
        chk("ch0_others_dark", 32'(led[3:1]), 32'd0);

        // Constant dark / constant lit / disabled
        send(1, 1, 0, 4);
        send(2, 1, 5, 0);
        send(3, 1, 0, 0);
        bad1 = 0; bad2 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (led[1] !== 1'b0) bad1++;
            if (led[2] !== 1'b1) bad2++;
        end
        chk("ch1_always_dark", 32'(bad1), 32'd0);
        chk("ch2_always_lit", 32'(bad2), 32'd0);
        chk("ch3_disabled", 32'(led[3]), 32'd0);

        // Request raised in a tick cycle stalls one cycle
        w = 0;
        while (tick !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("found_tick", 32'(tick), 32'd1);
        cfg_ch = 2'd3; cfg_en = 1'b1; cfg_on = DW'(1); cfg_off = DW'(1);
        cfg_valid = 1'b1;
        chk("ready_low_in_tick", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_tick", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("ch3_updated", 32'(led[3]), 32'd1);

        // Randomized configuration traffic
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end
        repeat (100) @(negedge clk);

        // Mid-blink reset pulse
        send(0, 1, 2, 3);
        send(1, 1, 3, 0);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_pulse_led", 32'(led), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9)  chk("post_rst_tick9", 32'(tick), 32'd0);
            if (c == 10) chk("post_rst_tick10", 32'(tick), 32'd1);
        end
        repeat (100) @(negedge clk);
        chk("post_rst_dark", 32'(led), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
